// File: rtl/apb_modport_pkg.sv
// Shared types and default sizing for the APB slave memory block.
package apb_modport_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 64;

endpackage

// File: rtl/apb_modport_if.sv
// APB bus bundle; the master drives the request side, the slave answers with ready/error/data.
interface apb_modport_if
    import apb_modport_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  psel;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_modport_mem.sv
// Word storage: one synchronous write port, one combinational read port, async clear to zero.
module apb_modport_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_modport.sv
// APB slave with word storage; define APB_WAIT_STATE_EN to insert one wait state per transfer.
module apb_modport
    import apb_modport_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_modport_if.slave  bus
);

    localparam int          IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned DEPTH_U = MEM_DEPTH;

    state_t                state_q;
    state_t                state_d;
    logic                  wait_done;
    logic                  ready;
    logic                  addr_err;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;

`ifdef APB_WAIT_STATE_EN
    logic wait_q;
    logic wait_d;

    // Set during the first ACCESS cycle so the second one completes.
    always_comb begin
        wait_d = (state_q == ACCESS) && bus.psel && !wait_q;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign wait_done = wait_q;
`else
    assign wait_done = 1'b1;
`endif

    // Dropping psel in ACCESS must never complete the transfer.
    assign ready    = (state_q == ACCESS) && bus.psel && wait_done;
    assign addr_err = (32'(bus.paddr) >= DEPTH_U);
    assign wr_en    = ready && bus.pwrite && !addr_err;
    assign idx      = bus.paddr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = bus.penable ? IDLE : SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    apb_modport_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (pclk),
        .rst_n (presetn),
        .we    (wr_en),
        .waddr (idx),
        .wdata (bus.pwdata),
        .raddr (idx),
        .rdata (rd_word)
    );

    assign bus.pready  = ready;
    assign bus.pslverr = ready && addr_err;
    assign bus.prdata  = (ready && !bus.pwrite && !addr_err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_modport.sv
// Bench for apb_modport: directed protocol/reset/error cases plus random traffic against an array model.
module tb_apb_modport;

    localparam int DEPTH = 64;
`ifdef APB_WAIT_STATE_EN
    localparam int EXP_WAITS = 1;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   in_setup = 1'b0;
    logic [31:0] model_mem [DEPTH];

    apb_modport_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_modport #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Master-side transfer; chain_next leaves the bus in setup for an immediate follow-on.
    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input bit chain_next, output logic [31:0] rdata,
                            output logic err, output int waits, output bit ok);
        rdata = '0;
        err   = 1'b0;
        waits = 0;
        ok    = 1'b0;
        if (!in_setup) begin
            bus.psel = 1'b1; bus.penable = 1'b0;
            bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wdata;
            tick();
        end
        bus.paddr = addr; bus.pwrite = wr; bus.pwdata = wdata; bus.penable = 1'b1;
        #1;
        check("setup_pready", {31'b0, bus.pready}, 32'd0);
        tick();
        for (int c = 0; c < 8; c++) begin
            if (bus.pready) begin
                err   = bus.pslverr;
                rdata = bus.prdata;
                ok    = 1'b1;
                break;
            end
            waits++;
            tick();
        end
        if (!ok) begin
            check("pready_timeout", 32'd0, 32'd1);
            bus.psel = 1'b0; bus.penable = 1'b0;
            in_setup = 1'b0;
            tick();
            return;
        end
        if (chain_next) bus.penable = 1'b0;
        tick();
        if (chain_next) begin
            in_setup = 1'b1;
        end else begin
            bus.psel = 1'b0; bus.penable = 1'b0;
            in_setup = 1'b0;
        end
    endtask

    task automatic do_xfer(input string tag, input bit wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input bit chain_next);
        logic [31:0] rdata;
        logic        err;
        int          waits;
        bit          ok;
        bit          exp_err;
        logic [31:0] exp_rd;
        exp_err = (int'(addr) >= DEPTH);
        exp_rd  = (wr || exp_err) ? 32'd0 : model_mem[addr[5:0]];
        apb_xfer(wr, addr, wdata, chain_next, rdata, err, waits, ok);
        if (ok) begin
            check({tag, "_waits"}, waits, EXP_WAITS);
            check({tag, "_pslverr"}, {31'b0, err}, {31'b0, exp_err});
            check({tag, "_prdata"}, rdata, exp_rd);
        end
        if (wr && !exp_err) model_mem[addr[5:0]] = wdata;
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0;
        bus.pwrite = 1'b0; bus.pwdata = '0;
        clear_model();

        // Outputs held at zero while in reset.
        repeat (2) tick();
        check("rst_pready", {31'b0, bus.pready}, 32'd0);
        check("rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        check("rst_prdata", bus.prdata, 32'd0);
        presetn = 1'b1;
        tick();

        do_xfer("wr5", 1'b1, 8'd5, 32'hDEADBEEF, 1'b0);
        do_xfer("rd5", 1'b0, 8'd5, 32'h0, 1'b0);

        do_xfer("b2b_wr0", 1'b1, 8'd0, 32'h000000A5, 1'b1);
        do_xfer("b2b_rd0", 1'b0, 8'd0, 32'h0, 1'b0);

        do_xfer("err_wr64", 1'b1, 8'd64, 32'h00001234, 1'b0);
        do_xfer("err_rd0", 1'b0, 8'd0, 32'h0, 1'b0);
        do_xfer("err_rd64", 1'b0, 8'd64, 32'h0, 1'b0);

        do_xfer("ws_wr1", 1'b1, 8'd1, 32'h00000055, 1'b0);
        do_xfer("ws_rd1", 1'b0, 8'd1, 32'h0, 1'b0);

        // penable without a setup phase must be ignored.
        do_xfer("pre_wr2", 1'b1, 8'd2, 32'h00000022, 1'b0);
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
        bus.paddr = 8'd2; bus.pwdata = 32'h00000BAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("noseq_pready", {31'b0, bus.pready}, 32'd0);
            tick();
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        tick();
        // psel dropped in ACCESS aborts with no write.
        bus.psel = 1'b1; bus.penable = 1'b0;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel = 1'b0;
        #1;
        check("abort_pready", {31'b0, bus.pready}, 32'd0);
        tick();
        bus.penable = 1'b0;
        tick();
        do_xfer("abort_rd2", 1'b0, 8'd2, 32'h0, 1'b0);

        // Reset in the middle of a write to addr 3.
        do_xfer("pre_wr3", 1'b1, 8'd3, 32'h00000077, 1'b0);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'd3; bus.pwdata = 32'h00000099;
        tick();
        bus.penable = 1'b1;
        tick();
        presetn = 1'b0;
        #1;
        check("midrst_pready", {31'b0, bus.pready}, 32'd0);
        check("midrst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        check("midrst_prdata", bus.prdata, 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        in_setup = 1'b0;
        tick();
        presetn = 1'b1;
        clear_model();
        do_xfer("midrst_rd3", 1'b0, 8'd3, 32'h0, 1'b0);

        // Random traffic, mostly in range, with random chaining.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a;
            bit         w;
            bit         ch;
            a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 15));
            w  = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            do_xfer("rand", w, a, $urandom, ch);
        end
        if (in_setup) do_xfer("rand_tail", 1'b0, 8'd0, 32'h0, 1'b0);
        tick();
        check("idle_pready", {31'b0, bus.pready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_modport.md
APB_MODPORT -- requirements
Module: apb_modport

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 8, the width of the APB address bus.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, the width of the APB read and write data buses.
REQ-003 The module SHALL have parameter MEM_DEPTH, default 64, the number of DATA_WIDTH-bit storage words.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, exposed as the two ports below.
REQ-005 pclk  input  1  APB clock; all state changes on its rising edge.
REQ-006 presetn  input  1  asynchronous active-low reset.
REQ-007 psel  input  1  slave select.
REQ-008 penable  input  1  access-phase strobe.
REQ-009 paddr  input  ADDR_WIDTH  word address.
REQ-010 pwrite  input  1  1 = write, 0 = read.
REQ-011 pwdata  input  DATA_WIDTH  write data.
REQ-012 pready  output  1  transfer completes this cycle.
REQ-013 pslverr  output  1  transfer error; valid only while pready is 1.
REQ-014 prdata  output  DATA_WIDTH  read data; valid only while pready is 1 on a read.

Function
REQ-015 The module SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-016 The FSM SHALL move IDLE->SETUP when psel=1 and penable=0.
REQ-017 In IDLE, penable=1 without a preceding SETUP SHALL be ignored: the FSM stays in IDLE and pready stays 0.
REQ-018 The FSM SHALL move SETUP->ACCESS when psel=1 and penable=1; if psel=0 it SHALL return to IDLE.
REQ-019 In ACCESS, pready SHALL be combinational: 1 when the wait count is satisfied (REQ-030/031), otherwise 0.
REQ-020 When ACCESS completes (pready=1), the FSM SHALL go to SETUP if psel=1 and penable=0 in that cycle, otherwise to IDLE.
REQ-021 If psel drops during ACCESS before pready=1, the FSM SHALL abort to IDLE with no write.
REQ-022 An address is in error when paddr >= MEM_DEPTH; pslverr SHALL equal this condition while pready=1 and SHALL be 0 otherwise.
REQ-023 A write SHALL update word paddr with pwdata at the rising edge where pready=1, pwrite=1 and there is no error; an errored write SHALL leave storage unchanged.
REQ-024 For a read, prdata SHALL be mem[paddr] while pready=1 with no error; it SHALL be 0 on an errored read and 0 in all other cycles.
REQ-025 paddr, pwrite and pwdata SHALL be sampled in the completion cycle; they SHALL be treated as stable from SETUP to completion.

Reset
REQ-026 Asserting presetn low SHALL immediately force the FSM to IDLE and clear the wait counter.
REQ-027 While presetn is low, pready, pslverr and prdata SHALL be 0 and all storage words SHALL be cleared to 0.
REQ-028 A reset asserted mid-transfer SHALL abort the transfer with no storage update.
REQ-029 After presetn rises, the first SETUP SHALL be accepted at the next rising edge of pclk.

Configuration
REQ-030 When macro APB_WAIT_STATE_EN is defined, every transfer SHALL have exactly one wait state: pready=0 in the first ACCESS cycle and 1 in the second, so SETUP to completion takes 3 cycles.
REQ-031 When APB_WAIT_STATE_EN is undefined, pready SHALL be 1 in the first ACCESS cycle (zero-wait, 2-cycle transfer) and no wait counter SHALL be synthesized.

Structure
REQ-032 Package apb_modport_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default width/depth constants.
REQ-033 Storage SHALL be a sub-module apb_modport_mem (write port, combinational read port, async clear), instantiated once.

Verification
REQ-034 Reset check: presetn=0 mid-write to addr 3 -> pready=0, pslverr=0, prdata=0; a later read of addr 3 returns 0x0.
REQ-035 Write/read, zero-wait: write 0xDEADBEEF to addr 5 -> pready=1 in the 2nd cycle, pslverr=0; read addr 5 -> prdata=0xDEADBEEF.
REQ-036 Error: write 0x1234 to addr 64 -> pready=1, pslverr=1, storage unchanged; read addr 64 -> pslverr=1, prdata=0.
REQ-037 Back-to-back: write addr 0 = 0xA5 immediately followed by read addr 0, no IDLE between -> second transfer returns 0xA5.
REQ-038 Wait state (APB_WAIT_STATE_EN defined): write addr 1 = 0x55 -> pready=0 in the 1st ACCESS cycle and 1 in the 2nd; readback returns 0x55.
REQ-039 Protocol: penable=1 with no SETUP, then psel dropped in ACCESS -> pready stays 0 and no storage change.
